// File: rtl/alu_cc_unit.sv
// alu_cc_unit: registered Y86-64 execute-stage ALU owning the ZF/SF/OF condition codes
// and decoding the jump/cmov condition from them.
module alu_cc_unit #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic         stall_i,
  input  logic [1:0]   alu_fun_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         set_cc_i,
  input  logic [3:0]   cond_fn_i,
  output logic         out_valid_o,
  output logic [W-1:0] result_o,
  output logic         of_o,
  output logic         zf_o,
  output logic         sf_o,
  output logic         of_cc_o,
  output logic         cnd_o
);
  logic [W-1:0] r, result_q, result_d;
  logic         ovf, acc, upd, so;
  logic         vld_q, vld_d, of_q, of_d, zf_q, zf_d, sf_q, sf_d, ofc_q, ofc_d;
  logic [15:0]  cnd_tbl;
  always_comb begin
    r = alu_fun_i == 2'd0 ? a_i + b_i :
        alu_fun_i == 2'd1 ? a_i - b_i :
        alu_fun_i == 2'd2 ? a_i & b_i : a_i ^ b_i;
    ovf = alu_fun_i == 2'd0 ? (a_i[W-1] == b_i[W-1]) && (r[W-1] != a_i[W-1]) :
          alu_fun_i == 2'd1 ? (a_i[W-1] != b_i[W-1]) && (r[W-1] != a_i[W-1]) : 1'b0;
    acc = in_valid_i && !stall_i;
    upd = acc && set_cc_i;
    vld_d = stall_i ? vld_q : in_valid_i;
    result_d = acc ? r : result_q;
    of_d = acc ? ovf : of_q;
    zf_d = upd ? (r == '0) : zf_q;
    sf_d = upd ? r[W-1] : sf_q;
    ofc_d = upd ? ovf : ofc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      result_q <= '0;
      of_q <= 1'b0;
      zf_q <= 1'b1;
      sf_q <= 1'b0;
      ofc_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      result_q <= result_d;
      of_q <= of_d;
      zf_q <= zf_d;
      sf_q <= sf_d;
      ofc_q <= ofc_d;
    end
  end
  // Condition table indexed by cond_fn: always, le, l, e, ne, ge, g, then never.
  assign so = sf_q ^ ofc_q;
  assign cnd_tbl = {9'b0, !so && !zf_q, !so, !zf_q, zf_q, so, so | zf_q, 1'b1};
  assign cnd_o = cnd_tbl[cond_fn_i];
  assign out_valid_o = vld_q;
  assign result_o = result_q;
  assign of_o = of_q;
  assign zf_o = zf_q;
  assign sf_o = sf_q;
  assign of_cc_o = ofc_q;
endmodule
